// File: rtl/multi_driver_core.sv
// Multi-channel H-bridge sequencer: shared pattern memory stepped at a programmable rate,
// one-shot/loop playback, per-channel inversion and break-before-make dead time.

module multi_driver_chan #(
  parameter int DEAD_TIME = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_en_i,
  input  logic       req_pol_i,
  output logic [1:0] drv_o
);
  localparam int CW = $clog2(DEAD_TIME + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pol_q, pol_d, seen_q, seen_d;
  logic [1:0]    drv_q, drv_d;

  // The drive register only ever takes 00, 10 or 01, so p and n can never overlap.
  always_comb begin
    cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    pol_d  = pol_q;
    seen_d = seen_q;
    drv_d  = 2'b00;
    if (req_en_i) begin
      seen_d = 1'b1;
      pol_d  = req_pol_i;
      if (seen_q && (req_pol_i != pol_q)) cnt_d = CW'(DEAD_TIME - 1);
      else if (cnt_q == '0)               drv_d = {req_pol_i, ~req_pol_i};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      pol_q  <= 1'b0;
      seen_q <= 1'b0;
      drv_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      pol_q  <= pol_d;
      seen_q <= seen_d;
      drv_q  <= drv_d;
    end
  end

  assign drv_o = drv_q;
endmodule

module multi_driver_core #(
  parameter int CHANNELS           = 4,
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int PERIOD_WIDTH       = 16,
  parameter int DEAD_TIME          = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_write,
  input  logic [MEM_ADDRESS_LENGTH-1:0] cfg_address,
  input  logic [CHANNELS-1:0]           cfg_enable_in,
  input  logic [CHANNELS-1:0]           cfg_state_in,
  input  logic [PERIOD_WIDTH-1:0]       step_period,
  input  logic [MEM_ADDRESS_LENGTH-1:0] last_step,
  input  logic                          loop_mode,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          output_active,
  input  logic [CHANNELS-1:0]           invert_mask,
  output logic [2*CHANNELS-1:0]         driver_io,
  output logic                          busy,
  output logic [MEM_ADDRESS_LENGTH-1:0] step_index,
  output logic                          done
);
  localparam logic [MEM_ADDRESS_LENGTH-1:0] LAST_ADDR = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state_q, state_d;
  logic [MEM_ADDRESS_LENGTH-1:0]   step_q, step_d, last_eff;
  logic [PERIOD_WIDTH-1:0]         pre_q, pre_d;
  logic                            start_q, done_d, rd_vld_q, run_next;
  logic [2*CHANNELS-1:0]           mem_q [MEM_LENGTH];
  logic [2*CHANNELS-1:0]           rd_q;
  logic [CHANNELS-1:0]             req_en, req_pol;

  assign last_eff = (last_step > LAST_ADDR) ? LAST_ADDR : last_step;

  // Terminal uses >= so a period or last_step shrunk mid-run still ends the step cleanly.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start && !start_q && !stop) begin
        state_d = RUN;
        step_d  = '0;
        pre_d   = '0;
      end
      RUN: begin
        if (stop) state_d = IDLE;
        else if (pre_q >= step_period) begin
          pre_d = '0;
          if (step_q < last_eff) step_d = step_q + 1'b1;
          else begin
            done_d = 1'b1;
            if (loop_mode) step_d  = '0;
            else           state_d = IDLE;
          end
        end else pre_d = pre_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      pre_q    <= '0;
      start_q  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pre_q    <= pre_d;
      start_q  <= start;
      rd_vld_q <= (state_q == RUN);
    end
  end

  // Nonblocking write/read gives old data on a same-address collision.
  always_ff @(posedge clock) begin
    if (cfg_write && (cfg_address <= LAST_ADDR)) mem_q[cfg_address] <= {cfg_enable_in, cfg_state_in};
    rd_q <= mem_q[step_q];
  end

  // Gate with next state so stop and one-shot end blank the bridges with busy.
  assign run_next = (state_d == RUN);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign req_en[c]  = rd_q[CHANNELS+c] & rd_vld_q & output_active & run_next;
    assign req_pol[c] = rd_q[c] ^ invert_mask[c];
    multi_driver_chan #(.DEAD_TIME(DEAD_TIME)) u_chan (
      .clock     (clock),
      .reset     (reset),
      .req_en_i  (req_en[c]),
      .req_pol_i (req_pol[c]),
      .drv_o     (driver_io[2*c+1:2*c])
    );
  end

  assign busy       = (state_q == RUN);
  assign step_index = step_q;
  assign done       = done_d;
endmodule

// File: tb/tb_multi_driver_core.sv
// Bench for multi_driver_core: directed scenarios plus randomized run against a cycle model.

module tb_multi_driver_core;
  localparam int CH = 4, ML = 48, AW = 6, PW = 16, DT = 2;

  logic          clock = 1'b0;
  logic          reset, cfg_write, loop_mode, start, stop, output_active;
  logic [AW-1:0] cfg_address, last_step, step_index;
  logic [CH-1:0] cfg_enable_in, cfg_state_in, invert_mask;
  logic [PW-1:0] step_period;
  logic [2*CH-1:0] driver_io;
  logic          busy, done;

  int checks = 0, errors = 0;

  multi_driver_core #(.CHANNELS(CH), .MEM_LENGTH(ML), .MEM_ADDRESS_LENGTH(AW),
                      .PERIOD_WIDTH(PW), .DEAD_TIME(DT)) dut (
    .clock(clock), .reset(reset), .cfg_write(cfg_write), .cfg_address(cfg_address),
    .cfg_enable_in(cfg_enable_in), .cfg_state_in(cfg_state_in), .step_period(step_period),
    .last_step(last_step), .loop_mode(loop_mode), .start(start), .stop(stop),
    .output_active(output_active), .invert_mask(invert_mask), .driver_io(driver_io),
    .busy(busy), .step_index(step_index), .done(done));

  always #5 clock = ~clock;

  // ---------------- reference model (cycle timeline with timestamps) ----------------
  bit [CH-1:0] m_mem_en [ML];
  bit [CH-1:0] m_mem_st [ML];
  bit [CH-1:0] m_rd_en, m_rd_st;
  bit          m_rdv, m_run, m_start_q;
  int          m_step, m_pre, m_cyc;
  bit [1:0]    m_drv  [CH];
  bit          m_seen [CH];
  bit          m_last [CH];
  int          m_block[CH];

  initial begin
    for (int a = 0; a < ML; a++) begin m_mem_en[a] = '0; m_mem_st[a] = '0; end
    for (int c = 0; c < CH; c++) begin m_drv[c] = 0; m_seen[c] = 0; m_last[c] = 0; m_block[c] = 0; end
    m_rdv = 0; m_run = 0; m_start_q = 0; m_step = 0; m_pre = 0; m_cyc = 0;
  end

  function automatic int clamp_last();
    return (int'(last_step) > ML - 1) ? ML - 1 : int'(last_step);
  endfunction

  always @(posedge clock) begin
    bit nrun, req, pol;
    int nstep, npre, k;
    k = m_cyc + 1;
    if (reset) begin
      m_run = 0; m_step = 0; m_pre = 0; m_start_q = 0;
      for (int c = 0; c < CH; c++) begin m_drv[c] = 0; m_seen[c] = 0; m_last[c] = 0; m_block[c] = 0; end
      m_rd_en = m_mem_en[m_step]; m_rd_st = m_mem_st[m_step]; m_rdv = 0;
    end else begin
      nrun = m_run; nstep = m_step; npre = m_pre;
      if (!m_run) begin
        if (start && !m_start_q && !stop) begin nrun = 1; nstep = 0; npre = 0; end
      end else if (stop) nrun = 0;
      else if (m_pre >= int'(step_period)) begin
        npre = 0;
        if (m_step < clamp_last()) nstep = m_step + 1;
        else if (loop_mode) nstep = 0;
        else nrun = 0;
      end else npre = m_pre + 1;
      for (int c = 0; c < CH; c++) begin
        req = m_rd_en[c] & m_rdv & output_active & nrun;
        pol = m_rd_st[c] ^ invert_mask[c];
        if (!req) m_drv[c] = 2'b00;
        else if (m_seen[c] && pol != m_last[c]) begin
          m_last[c] = pol; m_block[c] = k + DT; m_drv[c] = 2'b00;
        end else begin
          m_seen[c] = 1; m_last[c] = pol;
          m_drv[c] = (k >= m_block[c]) ? (pol ? 2'b10 : 2'b01) : 2'b00;
        end
      end
      m_rd_en = m_mem_en[m_step]; m_rd_st = m_mem_st[m_step]; m_rdv = m_run;
      m_run = nrun; m_step = nstep; m_pre = npre; m_start_q = start;
    end
    if (cfg_write && int'(cfg_address) < ML) begin
      m_mem_en[cfg_address] = cfg_enable_in; m_mem_st[cfg_address] = cfg_state_in;
    end
    m_cyc = k;
  end

  // p and n of a channel must never be high together.
  always @(negedge clock) begin
    for (int c = 0; c < CH; c++) begin
      checks++;
      if ((driver_io[2*c+1] & driver_io[2*c]) === 1'b1) begin
        errors++; $display("FAIL overlap ch%0d t=%0t got %b required not 11", c, $time, driver_io[2*c+1 -: 2]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(); @(posedge clock); #1; endtask

  task automatic idle_inputs();
    cfg_write = 0; cfg_address = '0; cfg_enable_in = '0; cfg_state_in = '0;
    start = 0; stop = 0; output_active = 1; invert_mask = '0; loop_mode = 0;
    step_period = '0; last_step = '0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic wr(input int a, input logic [CH-1:0] en, input logic [CH-1:0] st);
    cfg_write = 1; cfg_address = AW'(a); cfg_enable_in = en; cfg_state_in = st;
    tick(); cfg_write = 0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < ML; a++) wr(a, '0, '0);
  endtask

  task automatic kick();
    start = 1; tick(); start = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs(); do_reset(); #2;
    checks++; if (driver_io !== '0) begin errors++; $display("FAIL rst_drv got %b required 0", driver_io); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    checks++; if (step_index !== '0) begin errors++; $display("FAIL rst_step got %0d required 0", step_index); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
    clear_mem();
    for (int a = 0; a < 4; a++) wr(a, 4'hF, 4'hF);
    step_period = 3; last_step = 3; loop_mode = 1; kick();
    for (int n = 0; n < 5; n++) tick();
    checks++; if (driver_io !== 8'hAA) begin errors++; $display("FAIL rst_pre got %h required aa", driver_io); end
    reset = 1; tick(); #1;
    checks++; if ({driver_io, busy, step_index, done} !== '0) begin
      errors++; $display("FAIL rst_mid got drv %h busy %b step %0d done %b required all 0", driver_io, busy, step_index, done);
    end
    reset = 0; tick();
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_drv;
    idle_inputs(); do_reset(); clear_mem();
    wr(0, 4'b0001, 4'b0001); wr(1, 4'b0001, 4'b0001); wr(2, 4'b0001, 4'b0000); wr(3, 4'b0000, 4'b0000);
    step_period = 3; last_step = 3; kick();
    for (int n = 0; n < 20; n++) begin
      #2;
      exp_drv = (n >= 2 && n <= 9) ? 2'b10 : (n == 12 || n == 13) ? 2'b01 : 2'b00;
      checks++; if (driver_io !== {6'b0, exp_drv}) begin errors++; $display("FAIL os_drv cyc %0d got %b required %b", n, driver_io, exp_drv); end
      checks++; if (busy !== (n <= 15)) begin errors++; $display("FAIL os_busy cyc %0d got %b", n, busy); end
      checks++; if (int'(step_index) !== ((n < 16) ? n / 4 : 3)) begin errors++; $display("FAIL os_step cyc %0d got %0d", n, step_index); end
      checks++; if (done !== (n == 15)) begin errors++; $display("FAIL os_done cyc %0d got %b", n, done); end
      tick();
    end
  endtask

  task automatic test_loop();
    idle_inputs(); do_reset();
    loop_mode = 1; last_step = 1; step_period = 0; kick();
    for (int n = 0; n < 10; n++) begin
      #2;
      checks++; if (int'(step_index) !== n % 2) begin errors++; $display("FAIL loop_step cyc %0d got %0d required %0d", n, step_index, n % 2); end
      checks++; if (done !== (n % 2 == 1)) begin errors++; $display("FAIL loop_done cyc %0d got %b", n, done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy cyc %0d got %b required 1", n, busy); end
      tick();
    end
    stop = 1; tick(); stop = 0; #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop got %b required 0", busy); end
  endtask

  task automatic test_invert();
    idle_inputs(); do_reset(); clear_mem();
    wr(0, 4'hF, 4'hF); invert_mask = 4'b0001; step_period = 7; last_step = 0; kick();
    for (int n = 0; n < 10; n++) begin
      #2;
      checks++; if (driver_io !== ((n >= 2 && n <= 7) ? 8'b10101001 : 8'h00)) begin
        errors++; $display("FAIL inv_drv cyc %0d got %b", n, driver_io);
      end
      checks++; if (done !== (n == 7)) begin errors++; $display("FAIL inv_done cyc %0d got %b", n, done); end
      tick();
    end
  endtask

  task automatic test_stop();
    idle_inputs(); do_reset(); clear_mem();
    for (int a = 0; a < 4; a++) wr(a, 4'hF, 4'hF);
    step_period = 3; last_step = 1; loop_mode = 1;
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    for (int n = 0; n < 4; n++) begin
      #2;
      checks++; if ({busy, driver_io} !== '0) begin errors++; $display("FAIL ss_idle cyc %0d busy %b drv %h required 0", n, busy, driver_io); end
      tick();
    end
    kick();
    for (int n = 0; n < 7; n++) tick();
    stop = 1; #2;
    checks++; if (driver_io !== 8'hAA) begin errors++; $display("FAIL stop_pre got %h required aa", driver_io); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got %b required 0", done); end
    tick(); stop = 0; #2;
    checks++; if ({busy, driver_io} !== '0) begin errors++; $display("FAIL stop_post busy %b drv %h required 0", busy, driver_io); end
    checks++; if (step_index !== 6'd1) begin errors++; $display("FAIL stop_hold got %0d required 1", step_index); end
  endtask

  task automatic test_output_active();
    idle_inputs(); do_reset(); clear_mem();
    wr(0, 4'hF, 4'hF); loop_mode = 1; last_step = 0; step_period = 3; kick();
    for (int n = 0; n < 12; n++) begin
      output_active = !(n == 6 || n == 7); #2;
      checks++; if (driver_io !== ((n >= 2 && n != 7 && n != 8) ? 8'hAA : 8'h00)) begin
        errors++; $display("FAIL oa_drv cyc %0d got %h", n, driver_io);
      end
      tick();
    end
  endtask

  task automatic test_last_clamp();
    idle_inputs(); do_reset();
    last_step = 6'd63; step_period = 0; kick();
    for (int n = 0; n <= 48; n++) begin
      #2;
      checks++; if (int'(step_index) !== ((n <= 47) ? n : 47)) begin errors++; $display("FAIL clamp_step cyc %0d got %0d", n, step_index); end
      checks++; if (done !== (n == 47)) begin errors++; $display("FAIL clamp_done cyc %0d got %b", n, done); end
      checks++; if (busy !== (n <= 47)) begin errors++; $display("FAIL clamp_busy cyc %0d got %b", n, busy); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [2*CH-1:0] exp_drv;
    logic exp_done;
    idle_inputs(); do_reset();
    for (int i = 0; i < 20000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      cfg_write = ($urandom_range(0, 3) == 0);
      cfg_address = AW'($urandom_range(0, 63));
      cfg_enable_in = CH'($urandom); cfg_state_in = CH'($urandom);
      start = ($urandom_range(0, 7) == 0); stop = ($urandom_range(0, 31) == 0);
      output_active = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) begin
        invert_mask = CH'($urandom); loop_mode = 1'($urandom);
        step_period = PW'($urandom_range(0, 3));
        last_step = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 5));
      end
      @(negedge clock);
      for (int c = 0; c < CH; c++) exp_drv[2*c +: 2] = m_drv[c];
      exp_done = m_run && !stop && (m_pre >= int'(step_period)) && (m_step >= clamp_last());
      checks++; if (driver_io !== exp_drv) begin errors++; $display("FAIL rnd_drv it %0d got %b required %b", i, driver_io, exp_drv); end
      checks++; if (busy !== m_run) begin errors++; $display("FAIL rnd_busy it %0d got %b required %b", i, busy, m_run); end
      checks++; if (int'(step_index) !== m_step) begin errors++; $display("FAIL rnd_step it %0d got %0d required %0d", i, step_index, m_step); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL rnd_done it %0d got %b required %b", i, done, exp_done); end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; idle_inputs();
    test_reset();
    test_oneshot();
    test_loop();
    test_invert();
    test_stop();
    test_output_active();
    test_last_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
